ysyx_23060208_axi_arbiter: RTL and testbench

- Two-master, one-slave AXI-lite arbiter. IFU instruction fetch and EXU load/store share a single unified SRAM slave.
- Sits between IFU/EXU and one sram instance in top, replacing the separate isram/dsram paths.
- Grants one whole transaction at a time (address through response).
- Round-robin on contention; passes response codes through unchanged.

---
 rtl/ysyx_23060208_axi_arbiter_pkg.sv | 30 +++
 rtl/ysyx_23060208_axi_arbiter_if.sv | 41 ++++
 rtl/ysyx_23060208_axi_arbiter.sv | 135 +++++++++++++
 tb/tb_ysyx_23060208_axi_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI-lite arbiter: FSM encodings,
// grant owner encoding, AXI response codes and default bus widths.
package ysyx_23060208_axi_arbiter_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    // Three-bit strobe matches the existing dsram wstrb encoding.
    localparam int AXI_STRB_WIDTH = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFU_RD = 2'd1,
        ARB_LSU_RD = 2'd2,
        ARB_LSU_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // An LSU that offers a write (either AW or W) is served as a write,
    // even if it is also presenting a read address.
    function automatic arb_state_t lsu_target(input logic wr_req);
        return wr_req ? ARB_LSU_WR : ARB_LSU_RD;
    endfunction

endpackage

// File: rtl/ysyx_23060208_axi_arbiter_if.sv
// AXI-lite port bundle (AR/R/AW/W/B). The master modport is the side that
// issues requests; the slave modport is the side that answers them.
interface ysyx_23060208_axi_arbiter_if
    import ysyx_23060208_axi_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int STRB_WIDTH = AXI_STRB_WIDTH
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic [DATA_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_23060208_axi_arbiter.sv
// Two-master / one-slave AXI-lite arbiter. IFU fetches and LSU loads/stores
// share one SRAM. A whole transaction (address through response) is granted
// at a time, ties are broken round-robin, and the channel mux is a pure
// function of the registered state so no payload is buffered here.
module ysyx_23060208_axi_arbiter
    import ysyx_23060208_axi_arbiter_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    ysyx_23060208_axi_arbiter_if.slave        ifu,
    ysyx_23060208_axi_arbiter_if.slave        lsu,
    ysyx_23060208_axi_arbiter_if.master       sram
);

    arb_state_t state_reg;
    grant_t     last_grant_reg;

    logic ifu_req;
    logic lsu_wr_req;
    logic lsu_req;

    assign ifu_req    = ifu.arvalid;
    assign lsu_wr_req = lsu.awvalid | lsu.wvalid;
    assign lsu_req    = lsu_wr_req | lsu.arvalid;

    // The IFU port only ever reads; its write-side inputs are deliberately ignored.
    logic unused_ifu_wr;
    assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                             ifu.wvalid, ifu.bready};

    // Arbitration FSM: pick a master in IDLE, hold the grant until the response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= GRANT_LSU;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    // On a tie the master that did not win last time goes first.
                    if (ifu_req && (!lsu_req || last_grant_reg == GRANT_LSU)) begin
                        state_reg      <= ARB_IFU_RD;
                        last_grant_reg <= GRANT_IFU;
                    end else if (lsu_req) begin
                        state_reg      <= lsu_target(lsu_wr_req);
                        last_grant_reg <= GRANT_LSU;
                    end
                end
                ARB_IFU_RD: begin
                    if (sram.rvalid && ifu.rready) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                ARB_LSU_RD: begin
                    if (sram.rvalid && lsu.rready) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                ARB_LSU_WR: begin
                    if (sram.bvalid && lsu.bready) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    // Channel mux: connect only the granted master's active channels; everything else reads 0.
    always_comb begin
        sram.araddr  = '0;
        sram.arvalid = 1'b0;
        sram.rready  = 1'b0;
        sram.awaddr  = '0;
        sram.awvalid = 1'b0;
        sram.wdata   = '0;
        sram.wstrb   = '0;
        sram.wvalid  = 1'b0;
        sram.bready  = 1'b0;

        ifu.arready  = 1'b0;
        ifu.rdata    = '0;
        ifu.rresp    = AXI_RESP_OKAY;
        ifu.rvalid   = 1'b0;
        ifu.awready  = 1'b0;
        ifu.wready   = 1'b0;
        ifu.bresp    = AXI_RESP_OKAY;
        ifu.bvalid   = 1'b0;

        lsu.arready  = 1'b0;
        lsu.rdata    = '0;
        lsu.rresp    = AXI_RESP_OKAY;
        lsu.rvalid   = 1'b0;
        lsu.awready  = 1'b0;
        lsu.wready   = 1'b0;
        lsu.bresp    = AXI_RESP_OKAY;
        lsu.bvalid   = 1'b0;

        case (state_reg)
            ARB_IFU_RD: begin
                sram.araddr  = ifu.araddr;
                sram.arvalid = ifu.arvalid;
                ifu.arready  = sram.arready;
                ifu.rdata    = sram.rdata;
                ifu.rresp    = sram.rresp;
                ifu.rvalid   = sram.rvalid;
                sram.rready  = ifu.rready;
            end
            ARB_LSU_RD: begin
                sram.araddr  = lsu.araddr;
                sram.arvalid = lsu.arvalid;
                lsu.arready  = sram.arready;
                lsu.rdata    = sram.rdata;
                lsu.rresp    = sram.rresp;
                lsu.rvalid   = sram.rvalid;
                sram.rready  = lsu.rready;
            end
            ARB_LSU_WR: begin
                // AW and W are independent; either may complete first.
                sram.awaddr  = lsu.awaddr;
                sram.awvalid = lsu.awvalid;
                lsu.awready  = sram.awready;
                sram.wdata   = lsu.wdata;
                sram.wstrb   = lsu.wstrb;
                sram.wvalid  = lsu.wvalid;
                lsu.wready   = sram.wready;
                lsu.bresp    = sram.bresp;
                lsu.bvalid   = sram.bvalid;
                sram.bready  = lsu.bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI-lite arbiter. Masters and the SRAM
// slave are behavioural processes; handshakes are sampled on the falling
// edge and inputs change just after the rising edge.
module tb_ysyx_23060208_axi_arbiter;
    import ysyx_23060208_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ysyx_23060208_axi_arbiter_if ifu_bus ();
    ysyx_23060208_axi_arbiter_if lsu_bus ();
    ysyx_23060208_axi_arbiter_if sram_bus ();

    ysyx_23060208_axi_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .ifu  (ifu_bus),
        .lsu  (lsu_bus),
        .sram (sram_bus)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM slave model ----------------
    int          slv_rd_delay = 2;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;
    logic [31:0] last_araddr = '0;
    logic [31:0] last_awaddr = '0;
    logic [31:0] last_wdata  = '0;
    logic [2:0]  last_wstrb  = '0;
    int          wr_count = 0;

    function automatic logic [31:0] slv_mem(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : ~a;
    endfunction

    initial begin
        logic s_ar, s_r, s_aw, s_w, s_b;
        logic [31:0] s_araddr, s_awaddr, s_wdata;
        logic [2:0]  s_wstrb;
        logic rd_pending, aw_got, w_got;
        logic [31:0] rd_addr;
        int rd_cnt;
        rd_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0; rd_cnt = 0; rd_addr = '0;
        sram_bus.arready = 1'b0; sram_bus.rvalid = 1'b0; sram_bus.rdata = '0;
        sram_bus.rresp = 2'b00; sram_bus.awready = 1'b0; sram_bus.wready = 1'b0;
        sram_bus.bvalid = 1'b0; sram_bus.bresp = 2'b00;
        forever begin
            @(negedge clk);
            s_ar = sram_bus.arvalid && sram_bus.arready;
            s_r  = sram_bus.rvalid && sram_bus.rready;
            s_aw = sram_bus.awvalid && sram_bus.awready;
            s_w  = sram_bus.wvalid && sram_bus.wready;
            s_b  = sram_bus.bvalid && sram_bus.bready;
            s_araddr = sram_bus.araddr;
            s_awaddr = sram_bus.awaddr;
            s_wdata  = sram_bus.wdata;
            s_wstrb  = sram_bus.wstrb;
            @(posedge clk);
            #1;
            if (!rst) begin
                rd_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                sram_bus.arready = 1'b0; sram_bus.awready = 1'b0; sram_bus.wready = 1'b0;
                sram_bus.rvalid = 1'b0; sram_bus.bvalid = 1'b0;
            end else begin
                sram_bus.arready = 1'b1;
                sram_bus.awready = 1'b1;
                sram_bus.wready  = 1'b1;
                if (s_r) sram_bus.rvalid = 1'b0;
                if (s_b) sram_bus.bvalid = 1'b0;
                if (rd_pending) begin
                    if (rd_cnt <= 1) begin
                        sram_bus.rvalid = 1'b1;
                        sram_bus.rdata  = slv_mem(rd_addr);
                        sram_bus.rresp  = slv_rresp;
                        rd_pending = 1'b0;
                    end else begin
                        rd_cnt--;
                    end
                end
                if (s_ar) begin
                    rd_pending = 1'b1; rd_cnt = slv_rd_delay;
                    rd_addr = s_araddr; last_araddr = s_araddr;
                end
                if (s_aw) begin aw_got = 1'b1; last_awaddr = s_awaddr; end
                if (s_w)  begin w_got = 1'b1; last_wdata = s_wdata; last_wstrb = s_wstrb; end
                if (aw_got && w_got) begin
                    sram_bus.bvalid = 1'b1;
                    sram_bus.bresp  = slv_bresp;
                    aw_got = 1'b0; w_got = 1'b0;
                    wr_count++;
                end
            end
        end
    end

    // ---------------- master tasks ----------------
    task automatic ifu_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int ar_cyc, output int start_cyc);
        logic hs_ar, hs_r, done;
        done = 1'b0; data = '0; resp = 2'b11; ar_cyc = 0;
        ifu_bus.araddr = addr; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
        start_cyc = cyc_cnt;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (k == 0) chk("ifu_idle_arready", 32'(ifu_bus.arready), 32'd0);
            hs_ar = ifu_bus.arvalid && ifu_bus.arready;
            hs_r  = ifu_bus.rvalid && ifu_bus.rready;
            if (hs_ar) ar_cyc = cyc_cnt;
            if (hs_r) begin data = ifu_bus.rdata; resp = ifu_bus.rresp; end
            @(posedge clk);
            #2;
            if (hs_ar) ifu_bus.arvalid = 1'b0;
            if (hs_r) begin ifu_bus.rready = 1'b0; done = 1'b1; end
        end
        if (!done) begin
            chk("ifu_rd_timeout", 32'd0, 32'd1);
            ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0;
        end
        $display("ifu rd  addr=%h data=%h resp=%0d ar_cyc=%0d", addr, data, resp, ar_cyc);
    endtask

    task automatic lsu_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int ar_cyc, output int start_cyc);
        logic hs_ar, hs_r, done;
        done = 1'b0; data = '0; resp = 2'b11; ar_cyc = 0;
        lsu_bus.araddr = addr; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
        start_cyc = cyc_cnt;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (k == 0) chk("lsu_idle_arready", 32'(lsu_bus.arready), 32'd0);
            hs_ar = lsu_bus.arvalid && lsu_bus.arready;
            hs_r  = lsu_bus.rvalid && lsu_bus.rready;
            if (hs_ar) ar_cyc = cyc_cnt;
            if (hs_r) begin data = lsu_bus.rdata; resp = lsu_bus.rresp; end
            @(posedge clk);
            #2;
            if (hs_ar) lsu_bus.arvalid = 1'b0;
            if (hs_r) begin lsu_bus.rready = 1'b0; done = 1'b1; end
        end
        if (!done) begin
            chk("lsu_rd_timeout", 32'd0, 32'd1);
            lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
        end
        $display("lsu rd  addr=%h data=%h resp=%0d ar_cyc=%0d", addr, data, resp, ar_cyc);
    endtask

    // W is presented first; AW follows w_lead cycles later (0 = together).
    task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] strb, input int w_lead,
                             output logic [1:0] bresp, output int b_cyc,
                             output logic ifu_ar_seen);
        logic hs_aw, hs_w, hs_b, done, aw_on;
        int k;
        done = 1'b0; aw_on = 1'b0; k = 0;
        bresp = 2'b11; b_cyc = 0; ifu_ar_seen = 1'b0;
        lsu_bus.awaddr = addr; lsu_bus.wdata = data; lsu_bus.wstrb = strb;
        lsu_bus.wvalid = 1'b1; lsu_bus.bready = 1'b1;
        if (w_lead == 0) begin lsu_bus.awvalid = 1'b1; aw_on = 1'b1; end
        while (!done && k < 64) begin
            @(negedge clk);
            if (k == 0) chk("lsu_idle_wready", 32'({lsu_bus.awready, lsu_bus.wready}), 32'd0);
            hs_aw = lsu_bus.awvalid && lsu_bus.awready;
            hs_w  = lsu_bus.wvalid && lsu_bus.wready;
            hs_b  = lsu_bus.bvalid && lsu_bus.bready;
            if (hs_b) begin bresp = lsu_bus.bresp; b_cyc = cyc_cnt; end
            ifu_ar_seen = ifu_ar_seen | ifu_bus.arready;
            @(posedge clk);
            #2;
            k++;
            if (hs_aw) lsu_bus.awvalid = 1'b0;
            if (hs_w)  lsu_bus.wvalid = 1'b0;
            if (hs_b)  begin lsu_bus.bready = 1'b0; done = 1'b1; end
            if (!aw_on && !done && k >= w_lead) begin lsu_bus.awvalid = 1'b1; aw_on = 1'b1; end
        end
        if (!done) begin
            chk("lsu_wr_timeout", 32'd0, 32'd1);
            lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b0;
        end
        $display("lsu wr  addr=%h data=%h strb=%b bresp=%0d b_cyc=%0d", addr, data, strb, bresp, b_cyc);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d1, d2, d3;
        logic [1:0]  r1, r2, r3, br;
        int a1, a2, a3, s1, s2, s3, bc;
        logic seen;

        rst = 1'b0;
        ifu_bus.araddr = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0;
        ifu_bus.awaddr = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0;
        ifu_bus.wstrb = '0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
        lsu_bus.araddr = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
        lsu_bus.awaddr = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0;
        lsu_bus.wstrb = '0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(dut.state_reg), 32'(ARB_IDLE));
        chk("rst_last_grant", 32'(dut.last_grant_reg), 32'(GRANT_LSU));
        chk("rst_ifu_hs", 32'({ifu_bus.arready, ifu_bus.rvalid}), 32'd0);
        chk("rst_ifu_rdata", ifu_bus.rdata, 32'd0);
        chk("rst_lsu_hs", 32'({lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready,
                              lsu_bus.wready, lsu_bus.bvalid}), 32'd0);
        chk("rst_sram_hs", 32'({sram_bus.arvalid, sram_bus.rready, sram_bus.awvalid,
                               sram_bus.wvalid, sram_bus.bready}), 32'd0);
        chk("rst_sram_data", sram_bus.araddr | sram_bus.awaddr | sram_bus.wdata, 32'd0);
        @(posedge clk); #2; rst = 1'b1;

        // IFU alone
        slv_rd_delay = 2;
        ifu_read(32'h8000_0000, d1, r1, a1, s1);
        chk("ifu_rdata", d1, 32'h0000_0413);
        chk("ifu_rresp", 32'(r1), 32'd0);
        chk("ifu_ar_lat", 32'(a1 - s1), 32'd1);
        chk("ifu_slave_addr", last_araddr, 32'h8000_0000);
        @(negedge clk);
        chk("ifu_idle_after", 32'(dut.state_reg), 32'(ARB_IDLE));

        // Tie after reset: IFU first; IFU re-requests immediately and the repeat tie goes to LSU
        reset_pulse();
        fork
            begin
                ifu_read(32'h8000_0100, d1, r1, a1, s1);
                ifu_read(32'h8000_0200, d3, r3, a3, s3);
            end
            lsu_read(32'h8000_0300, d2, r2, a2, s2);
        join
        chk("tie1_ifu_first", 32'(a1 < a2), 32'd1);
        chk("tie2_lsu_first", 32'(a2 < a3), 32'd1);
        chk("tie_ifu1_data", d1, 32'h7FFF_FEFF);
        chk("tie_lsu_data", d2, 32'h7FFF_FCFF);
        chk("tie_ifu2_data", d3, 32'h7FFF_FDFF);

        // LSU write with W leading AW by 2 cycles; IFU requests during the write
        fork
            lsu_write(32'h8000_1000, 32'hDEAD_BEEF, 3'b111, 2, br, bc, seen);
            begin
                @(posedge clk); #2;
                ifu_read(32'h8000_0000, d1, r1, a1, s1);
            end
        join
        chk("wr_awaddr", last_awaddr, 32'h8000_1000);
        chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(last_wstrb), 32'd7);
        chk("wr_count", 32'(wr_count), 32'd1);
        chk("wr_bresp", 32'(br), 32'd0);
        chk("wr_ifu_arready_held", 32'(seen), 32'd0);
        chk("wr_ifu_after_data", d1, 32'h0000_0413);
        chk("wr_ifu_after_b", 32'(bc < a1), 32'd1);

        // LSU offers AW+W and AR together: write first, then read; SLVERR on B passes through
        slv_bresp = AXI_RESP_SLVERR;
        fork
            lsu_write(32'h8000_2000, 32'h1234_5678, 3'b001, 0, br, bc, seen);
            lsu_read(32'h8000_2004, d2, r2, a2, s2);
        join
        slv_bresp = AXI_RESP_OKAY;
        chk("wrrd_order", 32'(bc < a2), 32'd1);
        chk("wrrd_bresp", 32'(br), 32'(AXI_RESP_SLVERR));
        chk("wrrd_wstrb", 32'(last_wstrb), 32'd1);
        chk("wrrd_rdata", d2, 32'h7FFF_DFFB);

        // SLVERR on R passes through, FSM returns to IDLE
        slv_rresp = AXI_RESP_SLVERR;
        lsu_read(32'h8000_3000, d2, r2, a2, s2);
        slv_rresp = AXI_RESP_OKAY;
        chk("slverr_rresp", 32'(r2), 32'(AXI_RESP_SLVERR));
        chk("slverr_rdata", d2, 32'h7FFF_CFFF);
        @(negedge clk);
        chk("slverr_idle", 32'(dut.state_reg), 32'(ARB_IDLE));

        // Asynchronous reset while LSU_RD is waiting
        slv_rd_delay = 6;
        lsu_bus.araddr = 32'h8000_4000; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
        @(posedge clk); #2;
        chk("rstmid_granted", 32'(dut.state_reg), 32'(ARB_LSU_RD));
        chk("rstmid_pre_hs", 32'({sram_bus.arvalid, sram_bus.rready}), 32'd3);
        #1; rst = 1'b0;
        #1;
        chk("rstmid_hs_drop", 32'({sram_bus.arvalid, sram_bus.rready}), 32'd0);
        chk("rstmid_state", 32'(dut.state_reg), 32'(ARB_IDLE));
        chk("rstmid_lsu_arready", 32'(lsu_bus.arready), 32'd0);
        lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        slv_rd_delay = 2;
        ifu_read(32'h8000_0000, d1, r1, a1, s1);
        chk("post_rst_ifu_data", d1, 32'h0000_0413);
        chk("post_rst_ifu_lat", 32'(a1 - s1), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
